// File: rtl/noc_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : noc_cfg_scheduler
// Purpose  : Collects configure words from four processors and hands them to
//            the mesh one at a time. Each processor owns a single slot: a
//            request is latched only while its slot is empty, and the slot is
//            freed once the mesh reports ready for that processor. Slots are
//            served round-robin. An abort, or the optional watchdog, clears
//            all outstanding work and holds the mesh paths blocked for two
//            cycles.
//
// Parameters:
//   CFG_W          - width of one processor configure word
//   TIMEOUT_CYCLES - ready-wait limit in WAIT_READY (watchdog builds only)
//
// Build option:
//   NOC_CFG_TIMEOUT_EN - when defined, a watchdog aborts a grant that waits
//                        TIMEOUT_CYCLES cycles for ready and raises the
//                        sticky timeout_err. When undefined the scheduler
//                        waits for ready indefinitely and timeout_err is 0.
//
// Ports:
//   clock                   in   rising-edge clock
//   reset                   in   asynchronous active-high reset
//   req[3:0]                in   per-processor configure request (level)
//   cfg_in[4*CFG_W-1:0]     in   request words, processor i at [i*CFG_W +: CFG_W]
//   processor_ready_signals in   per-processor ready from the mesh
//   abort                   in   synchronous cancel of all work
//   p0..p3_configure        out  registered configure words to the mesh
//   block_all_paths         out  registered mesh path-block command
//   req_ack[3:0]            out  one-cycle capture pulse per processor
//   done[3:0]               out  one-cycle completion pulse per processor
//   busy                    out  high whenever the scheduler is not IDLE
//   timeout_err             out  sticky watchdog flag
//
// Revision : 1.0 - initial release
// ============================================================================
module noc_cfg_scheduler #(
    parameter int CFG_W          = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*CFG_W-1:0]   cfg_in,
    input  logic [3:0]           processor_ready_signals,
    input  logic                 abort,
    output logic [CFG_W-1:0]     p0_configure,
    output logic [CFG_W-1:0]     p1_configure,
    output logic [CFG_W-1:0]     p2_configure,
    output logic [CFG_W-1:0]     p3_configure,
    output logic                 block_all_paths,
    output logic [3:0]           req_ack,
    output logic [3:0]           done,
    output logic                 busy,
    output logic                 timeout_err
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    generate
        if (CFG_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("noc_cfg_scheduler: CFG_W and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_DONE       = 3'd3,
        S_FLUSH      = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    // r_grant doubles as last_grant: it holds the most recently granted
    // processor and seeds the next round-robin search.
    logic [1:0]         r_grant;
    logic [1:0]         w_grant_nx;

    logic [CFG_W-1:0]   r_slot [4];
    logic [3:0]         r_pending;
    logic [CFG_W-1:0]   r_cfg  [4];
    logic [3:0]         r_ack;
    logic [3:0]         r_done;
    logic               r_block;
    // Second-cycle marker inside FLUSH.
    logic               r_flush_cnt;

    logic [3:0]         w_capture;
    logic               w_clear_grant;   // free the granted slot this edge
    logic               w_timeout_hit;   // watchdog limit reached this cycle
    logic               w_drive_nx;      // next state presents a configure word
    logic [3:0]         w_done_nx;
    logic               w_block_nx;

    // ------------------------------------------------------------------------
    // Round-robin pick: first pending slot after 'last', wrapping, with
    // 'last' itself considered only after the other three. Scanning offsets
    // from far to near lets the nearest hit overwrite earlier ones.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] rr_pick(input logic [3:0] pend,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int off = 4; off >= 1; off--) begin
            idx = last + 2'(off);
            if (pend[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------------
`ifdef NOC_CFG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]    r_to_cnt;
    logic               r_timeout_err;
    logic               w_timeout_fire;

    // The counter restarts in every non-wait state, so it is zero on the
    // ISSUE->WAIT_READY edge and the hit lands TIMEOUT_CYCLES edges later.
    assign w_timeout_hit  = (r_state == S_WAIT_READY) &&
                            (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    // Ready and abort both outrank the watchdog.
    assign w_timeout_fire = w_timeout_hit && !abort &&
                            !processor_ready_signals[r_grant];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT_READY) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Per-processor slot, pending bit and configure output register
    // ------------------------------------------------------------------------
    generate
        for (genvar n = 0; n < 4; n++) begin : g_slot
            // A busy slot ignores its request; abort suppresses capture.
            assign w_capture[n] = !abort && req[n] && !r_pending[n];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_slot[n]    <= '0;
                    r_pending[n] <= 1'b0;
                    r_cfg[n]     <= '0;
                end else begin
                    if (w_capture[n]) begin
                        r_slot[n] <= cfg_in[n*CFG_W +: CFG_W];
                    end

                    // A slot being freed is still pending at that edge, so
                    // capture and clear never target the same bit together.
                    if (abort) begin
                        r_pending[n] <= 1'b0;
                    end else if (w_clear_grant && (r_grant == 2'(n))) begin
                        r_pending[n] <= 1'b0;
                    end else if (w_capture[n]) begin
                        r_pending[n] <= 1'b1;
                    end

                    // Word is visible only while its grant is in ISSUE or
                    // WAIT_READY; every other case drives zero.
                    if (w_drive_nx && (w_grant_nx == 2'(n))) begin
                        r_cfg[n] <= r_slot[n];
                    end else begin
                        r_cfg[n] <= '0;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 2'd3;
            r_flush_cnt <= 1'b0;
            r_block     <= 1'b0;
            r_ack       <= 4'b0000;
            r_done      <= 4'b0000;
        end else begin
            r_state     <= w_state_nx;
            r_grant     <= w_grant_nx;
            // An abort arriving inside FLUSH restarts the two-cycle window.
            r_flush_cnt <= (r_state == S_FLUSH && !abort) ? ~r_flush_cnt : 1'b0;
            r_block     <= w_block_nx;
            r_ack       <= w_capture;
            r_done      <= w_done_nx;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and next registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_clear_grant = 1'b0;
        w_drive_nx    = 1'b0;
        w_done_nx     = 4'b0000;
        w_block_nx    = 1'b0;

        if (abort) begin
            w_state_nx = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|r_pending) begin
                        w_grant_nx = rr_pick(r_pending, r_grant);
                        w_state_nx = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state_nx = S_WAIT_READY;
                end
                S_WAIT_READY: begin
                    // Only the granted processor's ready bit matters.
                    if (processor_ready_signals[r_grant]) begin
                        w_state_nx = S_DONE;
                    end else if (w_timeout_hit) begin
                        w_clear_grant = 1'b1;
                        w_state_nx    = S_FLUSH;
                    end
                end
                S_DONE: begin
                    w_clear_grant = 1'b1;
                    w_state_nx    = S_IDLE;
                end
                S_FLUSH: begin
                    if (r_flush_cnt) begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        w_drive_nx = (w_state_nx == S_ISSUE) || (w_state_nx == S_WAIT_READY);
        w_block_nx = (w_state_nx == S_FLUSH);
        if (w_state_nx == S_DONE) begin
            w_done_nx = 4'b0001 << w_grant_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign p0_configure    = r_cfg[0];
    assign p1_configure    = r_cfg[1];
    assign p2_configure    = r_cfg[2];
    assign p3_configure    = r_cfg[3];
    assign block_all_paths = r_block;
    assign req_ack         = r_ack;
    assign done            = r_done;
    assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_noc_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_cfg_scheduler
// Purpose  : Directed self-checking bench for noc_cfg_scheduler. Drives
//            hand-built request/ready/abort sequences and compares outputs
//            against hand-computed values one cycle at a time. The watchdog
//            scenario follows the NOC_CFG_TIMEOUT_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_noc_cfg_scheduler;

    localparam int CFG_W = 11;

    localparam logic [CFG_W-1:0] W0 = 11'b00001000011;
    localparam logic [CFG_W-1:0] W1 = 11'b00000100111;
    localparam logic [CFG_W-1:0] W2 = 11'b00010000001;
    localparam logic [CFG_W-1:0] W3 = 11'b01000000101;
    localparam logic [CFG_W-1:0] WA = 11'h155;
    localparam logic [CFG_W-1:0] WB = 11'h2AA;
    localparam logic [CFG_W-1:0] WC = 11'h3C3;

    logic               clock = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [4*CFG_W-1:0] cfg_in;
    logic [3:0]         rdy;
    logic               abort;
    logic [CFG_W-1:0]   p0_configure, p1_configure, p2_configure, p3_configure;
    logic               block_all_paths;
    logic [3:0]         req_ack;
    logic [3:0]         done;
    logic               busy;
    logic               timeout_err;
    logic [4*CFG_W-1:0] cfg_all;

    int n_checks = 0;
    int n_errors = 0;

    assign cfg_all = {p3_configure, p2_configure, p1_configure, p0_configure};

    noc_cfg_scheduler #(
        .CFG_W          (CFG_W),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clock                   (clock),
        .reset                   (reset),
        .req                     (req),
        .cfg_in                  (cfg_in),
        .processor_ready_signals (rdy),
        .abort                   (abort),
        .p0_configure            (p0_configure),
        .p1_configure            (p1_configure),
        .p2_configure            (p2_configure),
        .p3_configure            (p3_configure),
        .block_all_paths         (block_all_paths),
        .req_ack                 (req_ack),
        .done                    (done),
        .busy                    (busy),
        .timeout_err             (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4*CFG_W-1:0] cfg_at(input int k, input logic [CFG_W-1:0] w);
        logic [4*CFG_W-1:0] e;
        e = '0;
        e[k*CFG_W +: CFG_W] = w;
        return e;
    endfunction

    // Called in an IDLE cycle with slot k next in round-robin order and
    // ready[k] high: walks ISSUE, WAIT_READY, DONE and back to IDLE.
    task automatic run_xfer(input int k, input logic [CFG_W-1:0] w);
        logic [3:0] e_done;
        e_done = 4'b0001 << k;
        tick();
        check("issue_cfg",  cfg_all, cfg_at(k, w));
        check("issue_busy", busy, 1);
        check("issue_ack",  req_ack, 0);
        tick();
        check("wait_cfg",   cfg_all, cfg_at(k, w));
        check("wait_done",  done, 0);
        tick();
        check("done_pulse", done, e_done);
        check("done_cfg",   cfg_all, 0);
        tick();
        check("idle_done",  done, 0);
        check("idle_busy",  busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cfg"},   cfg_all, 0);
        check({tag, "_block"}, block_all_paths, 0);
        check({tag, "_ack"},   req_ack, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_to"},    timeout_err, 0);
    endtask

    initial begin
        reset = 1'b1; req = 4'b0; cfg_in = '0; rdy = 4'b0; abort = 1'b0;

        // ---- reset then idle ----
        tick(); tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick(); tick();
        check_idle_outputs("post_rst");

        // ---- four simultaneous requests, all ready: served 0,1,2,3 ----
        req = 4'b1111; cfg_in = {W3, W2, W1, W0}; rdy = 4'b1111;
        tick();
        check("all_ack", req_ack, 4'b1111);
        check("all_busy_idle", busy, 0);
        req = 4'b0;
        run_xfer(0, W0);
        run_xfer(1, W1);
        run_xfer(2, W2);
        run_xfer(3, W3);

        // ---- p2 waits on its own ready; ready[0] is ignored ----
        rdy = 4'b0001; req = 4'b0100; cfg_in = cfg_at(2, WC);
        tick();
        check("p2_ack", req_ack, 4'b0100);
        req = 4'b0;
        tick();
        check("p2_issue", cfg_all, cfg_at(2, WC));
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p2_wait_done", done, 0);
            check("p2_wait_cfg",  cfg_all, cfg_at(2, WC));
            check("p2_wait_busy", busy, 1);
        end

        // ---- abort in WAIT_READY, racing a new request ----
        abort = 1'b1; req = 4'b0001; cfg_in = cfg_at(0, WA);
        tick();
        abort = 1'b0; req = 4'b0;
        check("abt_block1", block_all_paths, 1);
        check("abt_cfg",    cfg_all, 0);
        check("abt_ack",    req_ack, 0);
        check("abt_done",   done, 0);
        tick();
        check("abt_block2", block_all_paths, 1);
        tick();
        check("abt_block3", block_all_paths, 0);
        check("abt_busy",   busy, 0);
        rdy = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abt_no_pend_busy", busy, 0);
            check("abt_no_pend_done", done, 0);
        end

        // ---- ready held low: watchdog, or indefinite wait ----
        rdy = 4'b0000; req = 4'b0001; cfg_in = cfg_at(0, WA);
        tick();
        req = 4'b0;
        tick();
        tick();
`ifdef NOC_CFG_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_early", timeout_err, 0);
        end
        tick();
        check("to_set",    timeout_err, 1);
        check("to_block1", block_all_paths, 1);
        check("to_done",   done, 0);
        check("to_cfg",    cfg_all, 0);
        tick();
        check("to_block2", block_all_paths, 1);
        tick();
        check("to_block3", block_all_paths, 0);
        check("to_sticky", timeout_err, 1);
        rdy = 4'b1111;
        tick(); tick();
        check("to_pend_clr", busy, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("nto_err",  timeout_err, 0);
        check("nto_busy", busy, 1);
        check("nto_cfg",  cfg_all, cfg_at(0, WA));
        check("nto_done", done, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(); tick();
        check("nto_flush_end", busy, 0);
`endif

        // ---- p1 re-request in its DONE cycle is ignored, then acked ----
        rdy = 4'b1111; req = 4'b0010; cfg_in = cfg_at(1, WA);
        tick();
        check("rr1_ack", req_ack, 4'b0010);
        req = 4'b0;
        tick(); tick(); tick();
        check("rr1_done", done, 4'b0010);
        req = 4'b0010; cfg_in = cfg_at(1, WB);
        tick();
        check("rr1_noack", req_ack, 0);
        tick();
        check("rr1_ack2", req_ack, 4'b0010);
        req = 4'b0;
        run_xfer(1, WB);

        // ---- round-robin from last_grant=1 with slots 0 and 3 pending ----
        req = 4'b1001; cfg_in = {WC, 11'd0, 11'd0, WB};
        tick();
        check("rr_ack", req_ack, 4'b1001);
        req = 4'b0;
        run_xfer(3, WC);
        run_xfer(0, WB);

        // ---- reset mid-transfer ----
        rdy = 4'b0000; req = 4'b1000; cfg_in = cfg_at(3, WA);
        tick();
        req = 4'b0;
        tick(); tick();
        check("mid_cfg_pre", cfg_all, cfg_at(3, WA));
        #2 reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_cfg",  cfg_all, 0);
        tick();
        check("mid_done", done, 0);
        reset = 1'b0;
        rdy = 4'b1111;
        tick();
        check_idle_outputs("mid_post");

        // ---- last_grant returns to 3 after reset: 0 before 2 ----
        req = 4'b0101; cfg_in = {11'd0, W2, 11'd0, W0};
        tick();
        req = 4'b0;
        run_xfer(0, W0);
        run_xfer(2, W2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time_limit_reached got=1 exp=0");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
